// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-source select arbiter.
// Imported by the arbiter and by any parent that builds the downstream mux.
package mux_arb_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRC1 = 2'd1,
        SRC2 = 2'd2
    } state_e;

    function automatic state_e other_src(input state_e s);
        return (s == SRC1) ? SRC2 : SRC1;
    endfunction

endpackage

// File: rtl/mux_select_arbiter.sv
// Burst-limited two-source arbiter with registered select and output stage.
// The parent instantiates the 2:1 data mux and drives it from sel.
module mux_select_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_1_data,
    input  logic             in_1_valid,
    output logic             in_1_ready,
    input  logic [WIDTH-1:0] in_2_data,
    input  logic             in_2_valid,
    output logic             in_2_ready,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] BURST_C = 4'(BURST);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_inc;
    logic             last_q, last_d;

    logic   can_load;
    logic   xfer1, xfer2, xfer;
    logic   own_valid, oth_valid;
    state_e oth;

    assign can_load   = !valid_q || out_ready;
    assign in_1_ready = (state_q == SRC1) && can_load;
    assign in_2_ready = (state_q == SRC2) && can_load;
    assign xfer1      = in_1_valid && in_1_ready;
    assign xfer2      = in_2_valid && in_2_ready;
    assign xfer       = xfer1 || xfer2;

    assign own_valid = (state_q == SRC1) ? in_1_valid : in_2_valid;
    assign oth_valid = (state_q == SRC1) ? in_2_valid : in_1_valid;
    assign oth       = other_src(state_q);
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        // last_q: 0 = source 1 served last, 1 = source 2
        if (xfer1) begin
            data_d  = in_1_data;
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (xfer2) begin
            data_d  = in_2_data;
            valid_d = 1'b1;
            last_d  = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (can_load) begin
            unique case (state_q)
                IDLE: begin
                    if (in_1_valid && in_2_valid)
                        state_d = last_q ? SRC1 : SRC2;
                    else if (in_1_valid)
                        state_d = SRC1;
                    else if (in_2_valid)
                        state_d = SRC2;
                end
                SRC1, SRC2: begin
                    if (xfer) begin
                        if (cnt_inc == BURST_C) begin
                            if (oth_valid)
                                state_d = oth;
                            else if (own_valid)
                                cnt_d = 4'd0;
                            else
                                state_d = IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (!own_valid) begin
                        state_d = oth_valid ? oth : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q)
            cnt_d = 4'd0;

        if (state_d == SRC1)
            sel_d = 1'b0;
        else if (state_d == SRC2)
            sel_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_1_ready && in_2_ready));
    a_ready_load: assert property (@(posedge clk) disable iff (!rst_n)
        (in_1_ready || in_2_ready) |-> can_load);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench for mux_select_arbiter: directed bursts, stalls,
// resets, then a random valid/ready run checked for order and loss.
module tb_mux_select_arbiter;
    import mux_arb_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_1_data = '0, in_2_data = '0;
    logic         in_1_valid = 1'b0, in_2_valid = 1'b0;
    logic         in_1_ready, in_2_ready;
    logic         sel;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] q1[$], q2[$], exp_q[$];
    bit   en1 = 1'b1, en2 = 1'b1;
    bit   rand_mode = 1'b0, auto_push = 1'b0, cnt_tog = 1'b0;
    int   toggles = 0, acc_cnt = 0, out_cnt = 0;
    logic sel_prev = 1'b0;

    mux_select_arbiter #(.WIDTH(W), .BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_1_data  (in_1_data),
        .in_1_valid (in_1_valid),
        .in_1_ready (in_1_ready),
        .in_2_data  (in_2_data),
        .in_2_valid (in_2_valid),
        .in_2_ready (in_2_ready),
        .sel        (sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Source driver: present queue heads just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            en1       = 1'($urandom_range(0, 1));
            en2       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_1_valid = en1 && (q1.size() > 0);
        in_1_data  = (q1.size() > 0) ? q1[0] : '0;
        in_2_valid = en2 && (q2.size() > 0);
        in_2_data  = (q2.size() > 0) ? q2[0] : '0;
    end

    // Monitor: handshakes that the coming edge will complete
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_1_valid && in_1_ready) begin
                check("sel_on_src1", sel, 0);
                if (auto_push) begin
                    exp_q.push_back(in_1_data);
                    acc_cnt++;
                end
                void'(q1.pop_front());
            end
            if (in_2_valid && in_2_ready) begin
                check("sel_on_src2", sel, 1);
                if (auto_push) begin
                    exp_q.push_back(in_2_data);
                    acc_cnt++;
                end
                void'(q2.pop_front());
            end
            if (out_valid && out_ready) begin
                if (auto_push) out_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0h want none",
                             out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (cnt_tog && sel !== sel_prev) toggles++;
        end
        sel_prev = sel;
    end

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1;
        out_ready = v;
    endtask

    task automatic wait_hs(input int which, input int n,
                           input string name);
        int got = 0;
        int k = 0;
        while (got < n && k < 50) begin
            @(negedge clk);
            k++;
            if (which == 1 && in_1_valid && in_1_ready) got++;
            if (which == 2 && in_2_valid && in_2_ready) got++;
        end
        check(name, got, n);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() > 0 || q1.size() > 0 || q2.size() > 0)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({name, "_drained"}, 32'(k < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v1[8] = '{4'h1, 4'h2, 4'h3, 4'h4,
                                4'h5, 4'h6, 4'h7, 4'h8};
        logic [W-1:0] v2[8] = '{4'h9, 4'hA, 4'hB, 4'hC,
                                4'hD, 4'hE, 4'hF, 4'h0};

        // Reset state, with source 1 already requesting
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel", sel, 0);
        q1.push_back(4'h3);
        exp_q.push_back(4'h3);
        @(negedge clk);
        check("rst_ready1", in_1_ready, 0);
        check("rst_ready2", in_2_ready, 0);
        rst_n = 1'b1;
        #1;
        check("first_cycle_ready1", in_1_ready, 0);
        check("first_cycle_ready2", in_2_ready, 0);
        wait_hs(1, 1, "t1_accept");
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 4'h3);
        check("t1_sel", sel, 0);
        wait_drain("t1", 20);

        // Both sources saturated: bursts of four, alternating
        do_reset();
        cnt_tog = 1'b1;
        foreach (v1[i]) q1.push_back(v1[i]);
        foreach (v2[i]) q2.push_back(v2[i]);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(v1[4*b+i]);
            for (int i = 0; i < 4; i++) exp_q.push_back(v2[4*b+i]);
        end
        wait_drain("t2", 100);
        cnt_tog = 1'b0;
        check("t2_sel_toggles", toggles, 3);

        // Output stall holds everything
        set_ready(1'b0);
        q1.push_back(4'hA);
        q1.push_back(4'h5);
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h5);
        wait_hs(1, 1, "t3_accept");
        @(negedge clk);
        check("t3_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_data", out_data, 4'hA);
            check("t3_hold_ready1", in_1_ready, 0);
            check("t3_hold_ready2", in_2_ready, 0);
        end
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t3_next_load", out_data, 4'h5);
        wait_drain("t3", 20);

        // Source 2 drops after two, source 1 takes over with fresh count
        q2 = '{4'h1, 4'h2, 4'hC, 4'hD};
        q1 = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        exp_q = '{4'h1, 4'h2, 4'h7, 4'h8, 4'h9,
                  4'hA, 4'hC, 4'hD, 4'hB};
        wait_hs(2, 2, "t4_src2_two");
        en2 = 1'b0;
        wait_hs(1, 1, "t4_src1_first");
        en2 = 1'b1;
        wait_drain("t4", 40);

        // Asynchronous reset in the middle of a source-2 burst
        auto_push = 1'b1;
        q2 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        wait_hs(2, 2, "t5_pre");
        @(posedge clk);
        #2;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_sel", sel, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_sel", sel, 0);
        q1.delete();
        q2.delete();
        exp_q.delete();
        auto_push = 1'b0;
        q1.push_back(4'h5);
        q2.push_back(4'h6);
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h6);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_post_valid", out_valid, 0);
        wait_drain("t5", 20);

        // Random valid/ready traffic
        acc_cnt = 0;
        out_cnt = 0;
        auto_push = 1'b1;
        for (int i = 0; i < 400; i++) begin
            q1.push_back(W'($urandom));
            q2.push_back(W'($urandom));
        end
        rand_mode = 1'b1;
        repeat (1000) @(negedge clk);
        rand_mode = 1'b0;
        en1 = 1'b1;
        en2 = 1'b1;
        set_ready(1'b1);
        wait_drain("t6", 3000);
        check("t6_accepted", acc_cnt, 800);
        check("t6_delivered", out_cnt, acc_cnt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, data width of each source and of out_data.
REQ-002 Parameter: BURST, 4, maximum consecutive transfers granted to one source before re-arbitration; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port: in_1_data  input  WIDTH  source-1 payload.
REQ-006 Port: in_1_valid  input  1  source-1 payload valid.
REQ-007 Port: in_1_ready  output  1  source-1 transfer accepted this cycle.
REQ-008 Port: in_2_data  input  WIDTH  source-2 payload.
REQ-009 Port: in_2_valid  input  1  source-2 payload valid.
REQ-010 Port: in_2_ready  output  1  source-2 transfer accepted this cycle.
REQ-011 Port: sel  output  1  registered select for the downstream 2:1 mux; 0 = source 1, 1 = source 2.
REQ-012 Port: out_data  output  WIDTH  registered payload of the last accepted transfer.
REQ-013 Port: out_valid  output  1  out_data holds an unconsumed payload.
REQ-014 Port: out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SRC1, SRC2.
REQ-016 The block SHALL define can_load = !out_valid || out_ready.
REQ-017 in_1_ready SHALL equal (state==SRC1) && can_load; in_2_ready SHALL equal (state==SRC2) && can_load; both are combinational.
REQ-018 A transfer on source x (valid && ready) SHALL load out_data with in_x_data and set out_valid to 1 on the next edge; latency is one cycle.
REQ-019 If out_ready is 1, out_valid is 1, and no transfer occurs, out_valid SHALL clear on the next edge.
REQ-020 While out_valid && !out_ready, out_data, out_valid, sel, state and burst count SHALL hold unchanged.
REQ-021 IDLE: if exactly one valid is high, the FSM SHALL go to that source's state; if both are high, it SHALL go to the source not last served; if neither is high, it SHALL stay in IDLE.
REQ-022 sel SHALL update on the edge that enters SRC1 (0) or SRC2 (1), and SHALL hold its last value in IDLE.
REQ-023 The burst count (4 bits) SHALL increment on each transfer and reset to 0 on every state change.
REQ-024 On the transfer that brings the count to BURST, the FSM SHALL go to the other source's state if that source's valid is high; otherwise it SHALL stay (count to 0) if its own valid is high; otherwise it SHALL go to IDLE.
REQ-025 In SRCx with can_load=1 and in_x_valid=0, the FSM SHALL go to the other source's state if that source's valid is high, else to IDLE.
REQ-026 A "last served" register SHALL update to x on every transfer from source x.
REQ-027 A source's data SHALL never be accepted while the FSM is in the other source's state; no payload is dropped or duplicated.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state=IDLE, out_valid=0, out_data=0, sel=0, count=0, and last served=source 2, so source 1 wins the first tie.
REQ-029 Reset asserted mid-burst or mid-stall SHALL discard the held payload, with no transfer reported after deassertion.
REQ-030 in_1_ready and in_2_ready SHALL be 0 throughout reset and in the first cycle after deassertion.

Structure
REQ-031 The state encoding (IDLE=2'd0, SRC1=2'd1, SRC2=2'd2) and the WIDTH/BURST defaults SHALL live in the shared package mux_arb_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the downstream mux SHALL be instantiated by the parent, driven by sel.

Verification
REQ-033 Reset, then in_1_valid=1 with data 4'h3 and out_ready=1 -> sel=0; out_data=4'h3 and out_valid=1 one cycle after acceptance.
REQ-034 Both sources valid continuously with BURST=4 and out_ready=1 -> four source-1 transfers, then four source-2 transfers, alternating; sel toggles only at burst boundaries.
REQ-035 out_ready=0 while out_valid=1 holding 4'hA -> both readys=0 and out_data stays 4'hA; out_ready=1 -> next payload loads on the following edge.
REQ-036 Source 2 alone valid, in_2_valid drops after 2 transfers, in_1_valid high -> FSM moves to SRC1, sel=0, and the count restarts.
REQ-037 rst_n pulsed low mid-burst with out_valid=1 -> out_valid=0 and out_data=0 asynchronously; first grant after reset goes to source 1 when both sources are valid.
REQ-038 Scoreboard checks over 1000 random valid/ready cycles -> output sequence equals the accepted input sequence in order, with no loss or duplication.
